// File: rtl/bus_split_arbiter.sv
// Round-robin bus arbiter with split-transaction parking and a grant-hold watchdog.
// Latency: a request sampled on one rising edge appears as a registered grant after that edge.
// Backpressure: requests stay pending until granted; a parked (split) master is masked until resumed.
//
// Ports:
//   clk, rst       system clock; asynchronous active-high reset
//   breq           per-master request, held high for the whole transaction
//   bgrant         registered one-hot (or zero) grant
//   split          per-master flag, high while that master is parked by a split
//   slave_split    1-cycle pulse: addressed slave splits the current owner
//   split_resume   1-cycle pulse: split slave is ready to complete
//   busy           registered |bgrant
//   owner          index of the current or most recent grant owner
//   timeout_err    1-cycle pulse when the watchdog revokes a grant
module bus_split_arbiter #(
    parameter  int NUM_MASTERS = 2,
    parameter  int TIMEOUT     = 1024,
    localparam int OWNER_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [NUM_MASTERS-1:0] split,
    input  logic                   slave_split,
    input  logic                   split_resume,
    output logic                   busy,
    output logic [OWNER_W-1:0]     owner,
    output logic                   timeout_err
);

    // Hold counter is wide enough to reach TIMEOUT; a 1-bit stub when the watchdog is off.
    localparam int                HOLD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Registered state
    state_t                   state_q;
    logic [OWNER_W-1:0]       rr_last;
    logic [OWNER_W-1:0]       split_owner;
    logic                     split_valid;
    logic                     resume_pending;
    logic [HOLD_W-1:0]        hold_cnt;
    logic [NUM_MASTERS-1:0]   block_mask;

    // Next-state values
    state_t                   state_d;
    logic [NUM_MASTERS-1:0]   bgrant_d;
    logic [NUM_MASTERS-1:0]   split_d;
    logic [OWNER_W-1:0]       owner_d;
    logic                     timeout_d;
    logic [OWNER_W-1:0]       rr_last_d;
    logic [OWNER_W-1:0]       split_owner_d;
    logic                     split_valid_d;
    logic                     resume_d;
    logic [HOLD_W-1:0]        hold_d;
    logic [NUM_MASTERS-1:0]   block_d;

    // Arbitration helpers
    logic [NUM_MASTERS-1:0]   split_mask;
    logic [NUM_MASTERS-1:0]   eligible;
    logic                     rr_found;
    logic [OWNER_W-1:0]       rr_idx;
    logic [OWNER_W-1:0]       cand_idx;
    int                       cand;
    logic                     do_grant;
    logic [OWNER_W-1:0]       grant_idx;

    // Round-robin search: first eligible master after rr_last, wrapping.
    always_comb begin
        split_mask = '0;
        if (split_valid) begin
            split_mask[split_owner] = 1'b1;
        end
        eligible = breq & ~block_mask & ~split_mask;

        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = int'(rr_last) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            cand_idx = OWNER_W'(cand);
            if (!rr_found && eligible[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        bgrant_d      = bgrant;
        split_d       = split;
        owner_d       = owner;
        timeout_d     = 1'b0;
        rr_last_d     = rr_last;
        split_owner_d = split_owner;
        split_valid_d = split_valid;
        resume_d      = resume_pending;
        hold_d        = hold_cnt;
        // A blocked master is released as soon as it drops its request.
        block_d       = block_mask & breq;
        do_grant      = 1'b0;
        grant_idx     = '0;

        case (state_q)
            IDLE: begin
                if (resume_pending && breq[split_owner]) begin
                    // Resumed split master jumps the round-robin queue.
                    do_grant  = 1'b1;
                    grant_idx = split_owner;
                end else begin
                    // Resumed master no longer asking: drop its priority claim.
                    if (resume_pending) begin
                        resume_d = 1'b0;
                    end
                    if (rr_found) begin
                        do_grant  = 1'b1;
                        grant_idx = rr_idx;
                    end
                end

                if (do_grant) begin
                    state_d             = GRANT;
                    bgrant_d            = '0;
                    bgrant_d[grant_idx] = 1'b1;
                    owner_d             = grant_idx;
                    rr_last_d           = grant_idx;
                    hold_d              = '0;
                    resume_d            = 1'b0;
                end
            end

            GRANT: begin
                if (!breq[owner]) begin
                    // Release always passes through IDLE, leaving one zero-grant cycle.
                    bgrant_d = '0;
                    state_d  = IDLE;
                end else if (slave_split && !split_valid) begin
                    split_d[owner] = 1'b1;
                    split_owner_d  = owner;
                    split_valid_d  = 1'b1;
                    bgrant_d       = '0;
                    state_d        = IDLE;
                end else if ((TIMEOUT != 0) && (hold_cnt == HOLD_LIMIT)) begin
                    bgrant_d       = '0;
                    timeout_d      = 1'b1;
                    block_d[owner] = 1'b1;
                    state_d        = IDLE;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                bgrant_d = '0;
            end
        endcase

        // Resume acts on the outstanding split regardless of FSM state. A split
        // arriving in the same cycle was already rejected above (split_valid=1).
        if (split_resume && split_valid) begin
            split_d[split_owner] = 1'b0;
            split_valid_d        = 1'b0;
            resume_d             = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bgrant         <= '0;
            split          <= '0;
            busy           <= 1'b0;
            owner          <= '0;
            timeout_err    <= 1'b0;
            rr_last        <= LAST_IDX;
            split_owner    <= '0;
            split_valid    <= 1'b0;
            resume_pending <= 1'b0;
            hold_cnt       <= '0;
            block_mask     <= '0;
        end else begin
            state_q        <= state_d;
            bgrant         <= bgrant_d;
            split          <= split_d;
            busy           <= |bgrant_d;
            owner          <= owner_d;
            timeout_err    <= timeout_d;
            rr_last        <= rr_last_d;
            split_owner    <= split_owner_d;
            split_valid    <= split_valid_d;
            resume_pending <= resume_d;
            hold_cnt       <= hold_d;
            block_mask     <= block_d;
        end
    end

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Testbench for bus_split_arbiter: two masters, watchdog shortened to 8 cycles.
// Expected grant order is queued as stimulus is applied and checked on each new grant.
// Direct checks cover reset, split parking/resume, watchdog revoke and async reset.
module tb_bus_split_arbiter;

    localparam int NM = 2;
    localparam int TO = 8;

    logic          clk          = 1'b0;
    logic          rst          = 1'b0;
    logic [NM-1:0] breq         = '0;
    logic          slave_split  = 1'b0;
    logic          split_resume = 1'b0;
    logic [NM-1:0] bgrant;
    logic [NM-1:0] split;
    logic          busy;
    logic [0:0]    owner;
    logic          timeout_err;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [NM-1:0] exp_q[$];
    logic [NM-1:0] prev_g   = '0;
    logic [NM-1:0] sb_exp;

    always #5 clk = ~clk;

    bus_split_arbiter #(
        .NUM_MASTERS (NM),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .breq         (breq),
        .bgrant       (bgrant),
        .split        (split),
        .slave_split  (slave_split),
        .split_resume (split_resume),
        .busy         (busy),
        .owner        (owner),
        .timeout_err  (timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        breq         = '0;
        slave_split  = 1'b0;
        split_resume = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (bgrant == '0 && n < 8) begin
            tick();
            n++;
        end
        check_eq("grant_wait", {31'b0, |bgrant}, 32'd1);
    endtask

    // Scoreboard: every new grant must match the next queued expectation;
    // invariants are checked every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            prev_g = '0;
        end else begin
            check_eq("invariants",
                     {29'b0, $onehot0(bgrant), ((bgrant & split) == '0), (busy == |bgrant)},
                     32'd7);
            if (bgrant != '0 && prev_g == '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("grant_unexpected", {30'b0, bgrant}, 32'd0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check_eq("grant_order", {30'b0, bgrant}, {30'b0, sb_exp});
                end
            end
            prev_g = bgrant;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gcnt;
        int tcnt;
        int tidx;
        int m;

        // Reset values
        #2 rst = 1'b1;
        #1;
        check_eq("rst_bgrant", {30'b0, bgrant}, 32'd0);
        check_eq("rst_split", {30'b0, split}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_owner", {31'b0, owner}, 32'd0);
        check_eq("rst_timeout", {31'b0, timeout_err}, 32'd0);

        // 1. single request, one-cycle grant latency, release
        do_reset();
        breq = 2'b01;
        exp_q.push_back(2'b01);
        tick();
        check_eq("t1_bgrant", {30'b0, bgrant}, 32'd1);
        check_eq("t1_owner", {31'b0, owner}, 32'd0);
        check_eq("t1_busy", {31'b0, busy}, 32'd1);
        breq = 2'b00;
        tick();
        check_eq("t1_release", {30'b0, bgrant}, 32'd0);
        check_eq("t1_busy_low", {31'b0, busy}, 32'd0);

        // 2. both requesting: alternation with one idle cycle between owners
        do_reset();
        breq = 2'b11;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        for (int g = 0; g < 4; g++) begin
            wait_grant();
            m = bgrant[1] ? 1 : 0;
            check_eq("t2_owner", {31'b0, owner}, g % 2);
            repeat (3) tick();
            breq[m] = 1'b0;
            tick();
            check_eq("t2_gap", {30'b0, bgrant}, 32'd0);
            breq[m] = 1'b1;
        end
        breq = 2'b00;
        tick();

        // 3. split parking, other master served, resume priority
        do_reset();
        breq = 2'b10;
        exp_q.push_back(2'b10);
        tick();
        check_eq("t3_m1_grant", {30'b0, bgrant}, 32'd2);
        slave_split = 1'b1;
        tick();
        slave_split = 1'b0;
        check_eq("t3_split", {30'b0, split}, 32'd2);
        check_eq("t3_split_drop", {30'b0, bgrant}, 32'd0);
        breq = 2'b11;
        exp_q.push_back(2'b01);
        tick();
        check_eq("t3_m0_grant", {30'b0, bgrant}, 32'd1);
        check_eq("t3_parked", {30'b0, split}, 32'd2);
        tick();
        split_resume = 1'b1;
        tick();
        split_resume = 1'b0;
        check_eq("t3_resumed", {30'b0, split}, 32'd0);
        check_eq("t3_m0_keeps", {30'b0, bgrant}, 32'd1);
        breq = 2'b10;
        exp_q.push_back(2'b10);
        tick();
        check_eq("t3_m0_drop", {30'b0, bgrant}, 32'd0);
        breq = 2'b11;
        tick();
        check_eq("t3_resume_grant", {30'b0, bgrant}, 32'd2);
        check_eq("t3_resume_owner", {31'b0, owner}, 32'd1);
        breq = 2'b00;
        tick();
        tick();

        // 4. watchdog: 8 granted cycles, single error pulse, blocked until re-request
        do_reset();
        breq = 2'b01;
        exp_q.push_back(2'b01);
        gcnt = 0;
        tcnt = 0;
        tidx = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bgrant[0]) gcnt++;
            if (timeout_err) begin
                tcnt++;
                tidx = i;
            end
        end
        check_eq("t4_grant_cycles", gcnt, 32'd8);
        check_eq("t4_err_pulses", tcnt, 32'd1);
        check_eq("t4_err_cycle", tidx, 32'd8);
        check_eq("t4_blocked", {30'b0, bgrant}, 32'd0);
        breq = 2'b00;
        tick();
        breq = 2'b01;
        exp_q.push_back(2'b01);
        tick();
        check_eq("t4_regrant", {30'b0, bgrant}, 32'd1);
        breq = 2'b00;
        tick();
        tick();

        // 5. second split while one is outstanding is ignored
        do_reset();
        breq = 2'b10;
        exp_q.push_back(2'b10);
        tick();
        slave_split = 1'b1;
        tick();
        slave_split = 1'b0;
        breq = 2'b11;
        exp_q.push_back(2'b01);
        tick();
        check_eq("t5_m0_grant", {30'b0, bgrant}, 32'd1);
        slave_split = 1'b1;
        tick();
        slave_split = 1'b0;
        check_eq("t5_keeps_grant", {30'b0, bgrant}, 32'd1);
        check_eq("t5_split_same", {30'b0, split}, 32'd2);
        check_eq("t5_owner", {31'b0, owner}, 32'd0);
        tick();
        check_eq("t5_still_grant", {30'b0, bgrant}, 32'd1);

        // 6. async reset mid-grant with a split outstanding
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_bgrant", {30'b0, bgrant}, 32'd0);
        check_eq("t6_split", {30'b0, split}, 32'd0);
        check_eq("t6_busy", {31'b0, busy}, 32'd0);
        check_eq("t6_timeout", {31'b0, timeout_err}, 32'd0);
        breq = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        breq = 2'b10;
        exp_q.push_back(2'b10);
        tick();
        check_eq("t6_m1_grant", {30'b0, bgrant}, 32'd2);
        check_eq("t6_no_split", {30'b0, split}, 32'd0);
        breq = 2'b00;
        tick();
        tick();

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
